// File: rtl/adrv9001_tx_seq.sv
// adrv9001_tx_seq: per-channel TX enable sequencer and AXIS sample gate for the
// ADRV9001/2 TX SSI path. Runs in the dclk_div domain; all inputs already synchronous.
// Optional feature macro: ADRV9001_TX_SEQ_UNDERFLOW_CNT_EN builds the per-channel
// saturating underflow counters; without it underflow_cnt is tied to zero.
module adrv9001_tx_seq #(
    parameter int NUM_CH     = 2,
    parameter int CNT_WIDTH  = 16,
    parameter int DATA_WIDTH = 32,
    parameter int SAMPLE_DIV = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_CH-1:0]            enable,
    input  logic [NUM_CH-1:0]            enable_mode,
    input  logic [NUM_CH*CNT_WIDTH-1:0]  enable_delay,
    input  logic [NUM_CH*CNT_WIDTH-1:0]  disable_delay,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_CH-1:0]            s_axis_tvalid,
    output logic [NUM_CH-1:0]            s_axis_tready,
    output logic [NUM_CH*DATA_WIDTH-1:0] m_data,
    input  logic [NUM_CH-1:0]            m_data_ready,
    output logic [NUM_CH-1:0]            adrv9001_enable,
    output logic [NUM_CH-1:0]            ssi_enable,
    output logic [NUM_CH*2-1:0]          state,
    output logic [NUM_CH*16-1:0]         underflow_cnt,
    input  logic                         underflow_clr
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WARMUP = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [TICK_W-1:0]    TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [TICK_W-1:0] tick_cnt_r;
    logic              tick_s;
    logic [NUM_CH-1:0] underflow_vec_s;

    assign tick_s = (tick_cnt_r == TICK_LAST);

    // Shared free-running sample tick divider.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tick_cnt_r <= {TICK_W{1'b0}};
        end else if (tick_s) begin
            tick_cnt_r <= {TICK_W{1'b0}};
        end else begin
            tick_cnt_r <= tick_cnt_r + {{(TICK_W-1){1'b0}}, 1'b1};
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [1:0]            state_r, state_nxt_s;
        logic [CNT_WIDTH-1:0]  cnt_r, cnt_nxt_s;
        logic                  adrv_r, ssi_r, adrv_nxt_s, ssi_nxt_s, live_s;
        logic [DATA_WIDTH-1:0] data_r;
        logic [CNT_WIDTH-1:0]  en_dly_s, dis_dly_s;
        logic                  mode_s;

        assign en_dly_s  = enable_delay[ch*CNT_WIDTH +: CNT_WIDTH];
        assign dis_dly_s = disable_delay[ch*CNT_WIDTH +: CNT_WIDTH];
        assign mode_s    = enable_mode[ch];

        // Next-state and delay counter: pin-mode sequencing, SPI mode parks in IDLE.
        always_comb begin
            state_nxt_s = state_r;
            cnt_nxt_s   = cnt_r;
            if (!mode_s) begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (!enable[ch]) begin
                            state_nxt_s = ST_IDLE;
                        end else if (en_dly_s == CNT_ZERO) begin
                            state_nxt_s = ST_ACTIVE;
                        end else begin
                            state_nxt_s = ST_WARMUP;
                            cnt_nxt_s   = en_dly_s;
                        end
                    end
                    ST_WARMUP, ST_ACTIVE: begin
                        if (!enable[ch]) begin
                            if (dis_dly_s == CNT_ZERO) begin
                                state_nxt_s = ST_IDLE;
                            end else begin
                                state_nxt_s = ST_DRAIN;
                                cnt_nxt_s   = dis_dly_s;
                            end
                        end else if ((state_r == ST_WARMUP) && tick_s) begin
                            cnt_nxt_s = cnt_r - CNT_ONE;
                            if (cnt_r == CNT_ONE) begin
                                state_nxt_s = ST_ACTIVE;
                            end else begin
                                state_nxt_s = ST_WARMUP;
                            end
                        end else begin
                            state_nxt_s = state_r;
                        end
                    end
                    ST_DRAIN: begin
                        if (enable[ch]) begin
                            state_nxt_s = ST_ACTIVE;
                        end else if (tick_s) begin
                            cnt_nxt_s = cnt_r - CNT_ONE;
                            if (cnt_r == CNT_ONE) begin
                                state_nxt_s = ST_IDLE;
                            end else begin
                                state_nxt_s = ST_DRAIN;
                            end
                        end else begin
                            state_nxt_s = ST_DRAIN;
                        end
                    end
                    default: begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = CNT_ZERO;
                    end
                endcase
            end
        end

        // Output decode: pin levels from the next state, data path liveness from the current one.
        always_comb begin
            live_s     = 1'b0;
            adrv_nxt_s = 1'b0;
            ssi_nxt_s  = 1'b0;
            if (!mode_s) begin
                live_s     = 1'b1;
                adrv_nxt_s = 1'b0;
                ssi_nxt_s  = 1'b1;
            end else begin
                live_s     = (state_r == ST_ACTIVE);
                adrv_nxt_s = (state_nxt_s != ST_IDLE);
                ssi_nxt_s  = (state_nxt_s == ST_ACTIVE) || (state_nxt_s == ST_DRAIN);
            end
        end

        // State, delay counter and registered enable pins.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                state_r <= ST_IDLE;
                cnt_r   <= CNT_ZERO;
                adrv_r  <= 1'b0;
                ssi_r   <= 1'b0;
            end else begin
                state_r <= state_nxt_s;
                cnt_r   <= cnt_nxt_s;
                adrv_r  <= adrv_nxt_s;
                ssi_r   <= ssi_nxt_s;
            end
        end

        // Sample register: forward on ready, zero-fill on underflow or when gated.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                data_r <= {DATA_WIDTH{1'b0}};
            end else if (!live_s) begin
                data_r <= {DATA_WIDTH{1'b0}};
            end else if (m_data_ready[ch]) begin
                data_r <= s_axis_tvalid[ch] ? s_axis_tdata[ch*DATA_WIDTH +: DATA_WIDTH]
                                            : {DATA_WIDTH{1'b0}};
            end else begin
                data_r <= data_r;
            end
        end

        assign underflow_vec_s[ch]                  = live_s & m_data_ready[ch] & ~s_axis_tvalid[ch];
        assign s_axis_tready[ch]                    = live_s & m_data_ready[ch];
        assign m_data[ch*DATA_WIDTH +: DATA_WIDTH]  = data_r;
        assign adrv9001_enable[ch]                  = adrv_r;
        assign ssi_enable[ch]                       = ssi_r;
        assign state[ch*2 +: 2]                     = state_r;

`ifdef ADRV9001_TX_SEQ_UNDERFLOW_CNT_EN
        logic [15:0] ucnt_r;

        // Saturating underflow counter; clear wins over increment.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                ucnt_r <= 16'd0;
            end else if (underflow_clr) begin
                ucnt_r <= 16'd0;
            end else if (underflow_vec_s[ch] && (ucnt_r != 16'hFFFF)) begin
                ucnt_r <= ucnt_r + 16'd1;
            end else begin
                ucnt_r <= ucnt_r;
            end
        end

        assign underflow_cnt[ch*16 +: 16] = ucnt_r;
`else
        assign underflow_cnt[ch*16 +: 16] = 16'd0;
`endif
    end

`ifndef ADRV9001_TX_SEQ_UNDERFLOW_CNT_EN
    logic unused_s;
    assign unused_s = underflow_clr ^ (^underflow_vec_s);
`endif

endmodule

// File: doc/adrv9001_tx_seq.md
Name: adrv9001_tx_seq

Overview:
Multi-channel transmit enable sequencer and sample gate for the ADRV9001/2 TX SSI path.
- Per channel: drives the ADRV9001 TX enable pin with programmable warm-up and disable delays, gates the AXIS sample stream, zero-fills, and counts underflows.
- Placement: between the user AXIS source and the per-channel serdes unpack/serializer, in the dclk_div domain.
- All control inputs are already synchronous to clk; CDC happens upstream.

Parameters:
- NUM_CH, 2: number of TX channels.
- CNT_WIDTH, 16: width of the delay counters and delay inputs.
- DATA_WIDTH, 32: packed IQ sample width.
- SAMPLE_DIV, 2: clk cycles per sample tick; must be >=1.

Ports:
- clk  in  1  dclk_div domain clock.
- rstn  in  1  asynchronous active-low reset.
- enable  in  NUM_CH  per-channel transmit request.
- enable_mode  in  NUM_CH  0 = spi mode (passthrough), 1 = pin mode (sequenced).
- enable_delay  in  NUM_CH*CNT_WIDTH  ticks from sequence start to ssi_enable.
- disable_delay  in  NUM_CH*CNT_WIDTH  ticks from enable fall to adrv9001_enable fall.
- s_axis_tdata  in  NUM_CH*DATA_WIDTH  IQ samples.
- s_axis_tvalid  in  NUM_CH  sample valid.
- s_axis_tready  out  NUM_CH  sample accepted.
- m_data  out  NUM_CH*DATA_WIDTH  sample to unpacker.
- m_data_ready  in  NUM_CH  unpacker ready for new word.
- adrv9001_enable  out  NUM_CH  ADRV9001 TX enable pin.
- ssi_enable  out  NUM_CH  serdes/unpack run; feeds active-high enable, inverted to reset.
- state  out  NUM_CH*2  current FSM state per channel.
- underflow_cnt  out  NUM_CH*16  per-channel underflow count.
- underflow_clr  in  1  clears all underflow counters.

Behaviour:
- Reset (rstn=0, async): tick counter=0, all FSMs IDLE, all counters 0; every output 0 except s_axis_tready, which is 0 by its combinational definition.
- Tick: free-running counter 0..SAMPLE_DIV-1; tick=1 when the counter equals SAMPLE_DIV-1. With SAMPLE_DIV=1, tick is always 1. The tick is shared by all channels.
- Channels are fully independent; channel i uses slice i of every vector.
- SPI mode (enable_mode=0): FSM forced to IDLE next cycle from any state; delay counter cleared.
  - ssi_enable=1, adrv9001_enable=0.
  - Data passes as in ACTIVE.
- Pin-mode FSM, state encoding IDLE=0, WARMUP=1, ACTIVE=2, DRAIN=3:
  - IDLE: adrv9001_enable=0, ssi_enable=0, m_data=0. On enable=1: if enable_delay==0, go to ACTIVE; else cnt<=enable_delay and go to WARMUP.
  - WARMUP: adrv9001_enable=1, ssi_enable=0, m_data=0. cnt decrements on tick. When tick and cnt==1, go to ACTIVE, so exactly enable_delay ticks are spent. If enable=0 (takes priority), cnt<=disable_delay and go to DRAIN, or to IDLE if disable_delay==0.
  - ACTIVE: adrv9001_enable=1, ssi_enable=1, data path live. If enable=0: cnt<=disable_delay and go to DRAIN, or to IDLE if disable_delay==0.
  - DRAIN: adrv9001_enable=1, ssi_enable=1, s_axis_tready=0, m_data driven 0 (zero flush). cnt decrements on tick; when tick and cnt==1, go to IDLE. enable=1 returns to ACTIVE next cycle with no warm-up.
- Outputs adrv9001_enable and ssi_enable are registered: they reflect the next state, so they change in the same cycle the state register changes.
- Delay inputs are sampled only at state entry; changes mid-count have no effect.
- Data path, active in ACTIVE or SPI mode:
  - s_axis_tready = m_data_ready (combinational); otherwise 0.
  - m_data is registered and updates only when m_data_ready=1:
    - tvalid=1: m_data <= tdata (1-cycle latency).
    - tvalid=0: m_data <= 0, counted as an underflow.
  - When m_data_ready=0, m_data holds.
  - In IDLE, WARMUP and DRAIN, m_data <= 0 every cycle.
- Underflow: increments on each underflow cycle and saturates at 16'hFFFF. underflow_clr=1 zeroes all counters; clear beats increment in the same cycle.
- Mode change mid-ACTIVE to spi mode: the channel drops adrv9001_enable the next cycle; no drain.

Optional Feature:
- Macro ADRV9001_TX_SEQ_UNDERFLOW_CNT_EN.
- Defined: underflow counters implemented as specified above.
- Undefined: counters not built; underflow_cnt tied 0; underflow_clr ignored. Data path is unchanged, and underflow still emits zero.

Test Plan:
- Reset: rstn=0 mid-ACTIVE with tvalid=1 and m_data_ready=1 -> all outputs 0 asynchronously and state=0. After release, a channel with enable=0 stays IDLE.
- Pin mode, SAMPLE_DIV=2, enable_delay=3: enable 0->1 ->
  - adrv9001_enable=1 one cycle later;
  - ssi_enable rises after exactly 3 ticks (5 or 6 clk depending on tick phase);
  - tready stays 0 until then.
- ACTIVE, disable_delay=4, enable 1->0 -> adrv9001_enable stays 1 for 4 ticks then 0; tready=0 and m_data=0 throughout DRAIN; end state=0.
- Re-trigger: enable back to 1 at tick 2 of DRAIN -> state=2 next cycle; tready follows m_data_ready; adrv9001_enable never dropped.
- Underflow: ACTIVE, m_data_ready=1, tvalid=0 for 10 cycles -> m_data=0 and underflow_cnt=10.
  - underflow_clr pulse -> 0.
  - 70000 underflow cycles -> 16'hFFFF.
  - Macro undefined -> counter always 0.
- Independence/SPI: ch0 enable_mode=0 with tvalid=1, tdata=32'h12345678 -> m_data=32'h12345678 one cycle later and adrv9001_enable[0]=0. Meanwhile ch1 sequences per scenario 2, unaffected.
